// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one shared single-ported memory
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q;
  logic        owner_q;      // 1 = data requester owns the transaction
  logic [3:0]  wmask_q;      // latched write mask, kept through WAIT
  logic [3:0]  cnt_q;
  logic [3:0]  streak_q;
  logic [3:0]  streak_d;
  logic        grant_data_d;
  logic        i_ack_q;
  logic        d_ack_q;
  logic        mem_en_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;

  // Data wins unless fetch has already waited through MAX_STREAK data grants
  always_comb begin
    grant_data_d = 1'b0;
    streak_d     = 4'd0;
    if (d_req && (!i_req || streak_q < 4'(MAX_STREAK))) begin
      grant_data_d = 1'b1;
      streak_d     = i_req ? streak_q + 4'd1 : 4'd0;
    end
  end

  // Transaction FSM; every output is a register updated on the state transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wmask_q     <= 4'd0;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
    end else begin
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wmask_q <= 4'd0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            owner_q     <= grant_data_d;
            streak_q    <= streak_d;
            mem_addr_q  <= grant_data_d ? d_addr  : i_addr;
            mem_wdata_q <= grant_data_d ? d_wdata : 32'd0;
            wmask_q     <= grant_data_d ? d_wmask : 4'd0;
            mem_wmask_q <= grant_data_d ? d_wmask : 4'd0;
            mem_en_q    <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= 4'(MEM_LAT);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (owner_q) begin
              if (wmask_q == 4'd0) d_rdata_q <= mem_rdata;
              d_ack_q <= 1'b1;
            end else begin
              i_rdata_q <= mem_rdata;
              i_ack_q   <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (MEM_LAT 2 and 1)
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req[2];
  logic        d_req[2];
  logic [31:0] i_addr[2];
  logic [31:0] d_addr[2];
  logic [31:0] d_wdata[2];
  logic [3:0]  d_wmask[2];
  logic [31:0] mem_rdata[2];
  logic        i_ack[2];
  logic        d_ack[2];
  logic        mem_en[2];
  logic        busy[2];
  logic [31:0] i_rdata[2];
  logic [31:0] d_rdata[2];
  logic [31:0] mem_addr[2];
  logic [31:0] mem_wdata[2];
  logic [3:0]  mem_wmask[2];

  mem_arbiter #(.MEM_LAT(2), .MAX_STREAK(4)) u0 (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wmask(d_wmask[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.MEM_LAT(1), .MAX_STREAK(2)) u1 (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wmask(d_wmask[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // transaction-level reference: grant cycle g, owner and latched fields per DUT
  int          g[2];
  int          strk[2];
  bit          own[2];
  logic [31:0] la[2];
  logic [31:0] lw[2];
  logic [3:0]  lm[2];
  logic [31:0] eir[2];
  logic [31:0] edr[2];
  int          men_c[2];
  logic [31:0] men_a[2];

  typedef struct {
    int          d;
    bit          dat;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  m;
    int          lat;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[7];

  int          lat;
  logic [31:0] rd;
  int          c0, da, ia, a1, a2, nack;
  logic [31:0] r1, r2;
  logic [6:0]  seq;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int max_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093;
      32'h0000_0004: return 32'h0000_0013;
      32'h0000_0008: return 32'h00A0_0113;
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_2000: return 32'h1234_5678;
      32'h0000_3000: return 32'hCAFE_F00D;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s [dut%0d cyc %0d] got %h want %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    g[d]    = -1000;
    strk[d] = 0;
    eir[d]  = 32'd0;
    edr[d]  = 32'd0;
  endtask

  // grant decision for the inputs present in the current cycle
  task automatic decide(input int d);
    bit dat;
    if (reset) begin
      model_reset(d);
    end else if (cyc > g[d] + 2 + lat_of(d) && (i_req[d] || d_req[d])) begin
      if (i_req[d] && d_req[d]) begin
        if (strk[d] < max_of(d)) begin
          dat = 1'b1;
          strk[d]++;
        end else begin
          dat = 1'b0;
          strk[d] = 0;
        end
      end else begin
        dat = d_req[d];
        strk[d] = 0;
      end
      g[d]   = cyc;
      own[d] = dat;
      la[d]  = dat ? d_addr[d]  : i_addr[d];
      lw[d]  = dat ? d_wdata[d] : 32'd0;
      lm[d]  = dat ? d_wmask[d] : 4'd0;
    end
  endtask

  task automatic check_dut(input int d);
    bit iss;
    bit ack;
    bit bsy;
    int L = lat_of(d);
    if (reset) begin
      chk(d, "rst_i_ack",   {31'd0, i_ack[d]},    32'd0);
      chk(d, "rst_d_ack",   {31'd0, d_ack[d]},    32'd0);
      chk(d, "rst_mem_en",  {31'd0, mem_en[d]},   32'd0);
      chk(d, "rst_busy",    {31'd0, busy[d]},     32'd0);
      chk(d, "rst_wmask",   {28'd0, mem_wmask[d]}, 32'd0);
      chk(d, "rst_addr",    mem_addr[d],          32'd0);
      chk(d, "rst_wdata",   mem_wdata[d],         32'd0);
      chk(d, "rst_i_rdata", i_rdata[d],           32'd0);
      chk(d, "rst_d_rdata", d_rdata[d],           32'd0);
      model_reset(d);
    end else begin
      iss = (cyc == g[d] + 1);
      ack = (cyc == g[d] + 2 + L);
      bsy = (cyc > g[d]) && (cyc <= g[d] + 2 + L);
      if (ack && lm[d] == 4'd0) begin
        if (own[d]) edr[d] = mem_val(la[d]);
        else        eir[d] = mem_val(la[d]);
      end
      chk(d, "mem_en", {31'd0, mem_en[d]}, {31'd0, iss});
      chk(d, "mem_wmask", {28'd0, mem_wmask[d]}, {28'd0, (iss ? lm[d] : 4'd0)});
      if (iss) begin
        chk(d, "mem_addr",  mem_addr[d],  la[d]);
        chk(d, "mem_wdata", mem_wdata[d], lw[d]);
      end
      chk(d, "i_ack",   {31'd0, i_ack[d]}, {31'd0, (ack && !own[d])});
      chk(d, "d_ack",   {31'd0, d_ack[d]}, {31'd0, (ack && own[d])});
      chk(d, "i_rdata", i_rdata[d], eir[d]);
      chk(d, "d_rdata", d_rdata[d], edr[d]);
      chk(d, "busy",    {31'd0, busy[d]}, {31'd0, bsy});
    end
  endtask

  // memory: returns data only in the cycle exactly MEM_LAT after mem_en
  task automatic mem_upd(input int d);
    if (mem_en[d]) begin
      men_c[d] = cyc;
      men_a[d] = mem_addr[d];
    end
    mem_rdata[d] = (cyc == men_c[d] + lat_of(d)) ? mem_val(men_a[d]) : $urandom;
  endtask

  task automatic step();
    decide(0);
    decide(1);
    @(negedge clk);
    cyc++;
    check_dut(0);
    check_dut(1);
    mem_upd(0);
    mem_upd(1);
  endtask

  task automatic run_txn(input int d, input bit dat, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] m, output int lt, output logic [31:0] r);
    int s;
    bit got;
    got = 1'b0;
    lt  = -1;
    r   = 32'd0;
    if (dat) begin
      d_req[d] = 1'b1; d_addr[d] = a; d_wdata[d] = w; d_wmask[d] = m;
    end else begin
      i_req[d] = 1'b1; i_addr[d] = a;
    end
    s = cyc;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (dat ? d_ack[d] : i_ack[d]) begin
        got = 1'b1;
        lt  = cyc - s;
        r   = dat ? d_rdata[d] : i_rdata[d];
      end
    end
    i_req[d] = 1'b0;
    d_req[d] = 1'b0;
  endtask

  task automatic drive_rand(input int d);
    if (!i_req[d]) begin
      if ($urandom_range(2) == 0) begin
        i_req[d] = 1'b1; i_addr[d] = $urandom;
      end
    end else if (i_ack[d] && $urandom_range(1) == 0) begin
      i_req[d] = 1'b0;
    end else begin
      i_addr[d] = $urandom;
    end
    if (!d_req[d]) begin
      if ($urandom_range(2) == 0) begin
        d_req[d] = 1'b1; d_addr[d] = $urandom; d_wdata[d] = $urandom;
        d_wmask[d] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
      end
    end else if (d_ack[d] && $urandom_range(1) == 0) begin
      d_req[d] = 1'b0;
    end else begin
      d_addr[d] = $urandom; d_wdata[d] = $urandom;
      d_wmask[d] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
    end
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 32'h100,  32'h0,        4'b0000, 4, 32'h0050_0093};
    tbl[1] = '{0, 1'b1, 32'h2000, 32'h0,        4'b0000, 4, 32'h1234_5678};
    tbl[2] = '{0, 1'b1, 32'h40,   32'hDEADBEEF, 4'b0011, 4, 32'h1234_5678};
    tbl[3] = '{0, 1'b0, 32'h4,    32'h0,        4'b0000, 4, 32'h0000_0013};
    tbl[4] = '{1, 1'b1, 32'h3000, 32'h0,        4'b0000, 3, 32'hCAFE_F00D};
    tbl[5] = '{1, 1'b1, 32'h3000, 32'hFFFFFFFF, 4'b1111, 3, 32'hCAFE_F00D};
    tbl[6] = '{1, 1'b0, 32'h8,    32'h0,        4'b0000, 3, 32'h00A0_0113};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      i_req[d] = 1'b0; d_req[d] = 1'b0; i_addr[d] = 32'd0; d_addr[d] = 32'd0;
      d_wdata[d] = 32'd0; d_wmask[d] = 4'd0; mem_rdata[d] = 32'd0;
      men_c[d] = -1000; men_a[d] = 32'd0; own[d] = 1'b0;
      la[d] = 32'd0; lw[d] = 32'd0; lm[d] = 4'd0;
      model_reset(d);
    end
    step(); step(); step();
    reset = 1'b0;
    step();

    // single transactions from the vector table
    for (int t = 0; t < 7; t++) begin
      run_txn(tbl[t].d, tbl[t].dat, tbl[t].a, tbl[t].w, tbl[t].m, lat, rd);
      chk(tbl[t].d, "tbl_lat",   32'(lat), 32'(tbl[t].lat));
      chk(tbl[t].d, "tbl_rdata", rd,       tbl[t].rd);
      step();
    end

    // simultaneous requests: data first, then fetch
    i_req[0] = 1'b1; i_addr[0] = 32'h100;
    d_req[0] = 1'b1; d_addr[0] = 32'h2000; d_wmask[0] = 4'd0; d_wdata[0] = 32'd0;
    c0 = cyc; da = -1; ia = -1;
    for (int k = 0; k < 40 && ia < 0; k++) begin
      step();
      if (d_ack[0]) begin da = cyc - c0; d_req[0] = 1'b0; end
      if (i_ack[0]) begin ia = cyc - c0; i_req[0] = 1'b0; end
    end
    chk(0, "simul_d_ack", 32'(da), 32'd4);
    chk(0, "simul_i_ack", 32'(ia), 32'd9);
    step();

    // starvation bound: four data grants, then fetch, then data again
    i_req[0] = 1'b1; i_addr[0] = 32'h300;
    d_req[0] = 1'b1; d_addr[0] = 32'h400; d_wmask[0] = 4'd0;
    seq = 7'd0; nack = 0;
    for (int k = 0; k < 200 && nack < 7; k++) begin
      step();
      if (d_ack[0]) begin seq = {seq[5:0], 1'b1}; nack++; end
      if (i_ack[0]) begin seq = {seq[5:0], 1'b0}; nack++; end
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    chk(0, "streak_count", 32'(nack), 32'd7);
    chk(0, "streak_order", {25'd0, seq}, 32'b1111011);
    step();

    // MEM_LAT=1 back-to-back fetches with req held
    i_req[1] = 1'b1; i_addr[1] = 32'h0;
    c0 = cyc; a1 = -1; a2 = -1; r1 = 32'd0; r2 = 32'd0;
    for (int k = 0; k < 40 && a2 < 0; k++) begin
      step();
      if (i_ack[1]) begin
        if (a1 < 0) begin a1 = cyc - c0; r1 = i_rdata[1]; i_addr[1] = 32'h4; end
        else begin a2 = cyc - c0; r2 = i_rdata[1]; i_req[1] = 1'b0; end
      end
    end
    chk(1, "b2b_ack1",   32'(a1), 32'd3);
    chk(1, "b2b_ack2",   32'(a2), 32'd7);
    chk(1, "b2b_rdata1", r1, 32'h0010_0093);
    chk(1, "b2b_rdata2", r2, 32'h0000_0013);
    step();

    // reset in the first WAIT cycle drops the fetch
    i_req[0] = 1'b1; i_addr[0] = 32'h200;
    step();
    chk(0, "wrst_issue", {31'd0, mem_en[0]}, 32'd1);
    step();
    chk(0, "wrst_busy", {31'd0, busy[0]}, 32'd1);
    reset = 1'b1;
    #1;
    chk(0, "wrst_now_busy",    {31'd0, busy[0]}, 32'd0);
    chk(0, "wrst_now_i_rdata", i_rdata[0], 32'd0);
    chk(0, "wrst_now_addr",    mem_addr[0], 32'd0);
    i_req[0] = 1'b0;
    step(); step();
    reset = 1'b0;
    nack = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (i_ack[0] || d_ack[0]) nack++;
    end
    chk(0, "wrst_no_ack", 32'(nack), 32'd0);
    run_txn(0, 1'b0, 32'h100, 32'd0, 4'd0, lat, rd);
    chk(0, "wrst_after_lat",   32'(lat), 32'd4);
    chk(0, "wrst_after_rdata", rd, 32'h0050_0093);
    step();

    // randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(299) == 0);
      drive_rand(0);
      drive_rand(1);
      step();
    end
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      i_req[d] = 1'b0; d_req[d] = 1'b0;
    end
    for (int k = 0; k < 10; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
